// File: rtl/interleaver_2_param.sv
// Second-permutation stage of the OFDM transmit interleaver: rotates each
// s-bit group by (column mod s), bit-serial in and out through two group buffers.
module interleaver_2_param #(
  parameter int           NUM_COLS       = 16,
  parameter int           COL_MULT       = 3,
  parameter int           MAX_S          = 3,
  parameter logic [1:0]   RESET_MAP_TYPE = 2'b11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_vld,
  output logic       din_rdy,
  input  logic       din_sig_flag,
  input  logic [1:0] din_map_type,
  output logic       dout,
  output logic       dout_vld,
  input  logic       dout_rdy,
  output logic [1:0] dout_map_type,
  output logic       dout_sym_last
);

  localparam int CW = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int KW = $clog2(COL_MULT * 6 + 1);
  localparam int SW = $clog2(MAX_S + 1);

  function automatic logic [2:0] nbpsc_of(input logic sig, input logic [1:0] mt);
    logic [2:0] nb;
    nb = 3'd1;
    if (!sig) begin
      case (mt)
        2'b00:   nb = 3'd1;
        2'b01:   nb = 3'd2;
        2'b10:   nb = 3'd4;
        default: nb = 3'd6;
      endcase
    end
    return nb;
  endfunction

  function automatic logic [SW-1:0] s_of(input logic [2:0] nb);
    logic [SW-1:0] s;
    case (nb)
      3'd4:    s = SW'(2);
      3'd6:    s = SW'(3);
      default: s = SW'(1);
    endcase
    return s;
  endfunction

  // Input-side counters and latched symbol context
  logic [SW-1:0] m_reg;
  logic [KW-1:0] k_reg;
  logic [CW-1:0] c_reg;
  logic [SW-1:0] r_reg;
  logic          sig_reg;
  logic [1:0]    map_reg;
  logic          wr_ptr_reg;

  // Output-side state
  logic          rd_ptr_reg;
  logic [SW-1:0] j_reg;

  // Per-buffer views gathered from the generate block
  logic [1:0]       full_v;
  logic [1:0]       last_v;
  logic [MAX_S-1:0] bits_v [2];
  logic [SW-1:0]    s_v    [2];
  logic [SW-1:0]    r_v    [2];
  logic [1:0]       map_v  [2];

  logic          sym_start;
  logic          cur_sig;
  logic [1:0]    cur_map;
  logic [2:0]    nb_cur;
  logic [SW-1:0] s_cur;
  logic [KW-1:0] l_cur;
  logic          in_fire;
  logic          grp_done;
  logic          col_done;
  logic          sym_done;

  logic [SW-1:0] rd_s;
  logic [SW:0]   sel_sum;
  logic [SW-1:0] sel;
  logic          out_fire;
  logic          out_grp_done;

  // The first bit of a symbol takes its context straight from the inputs
  assign sym_start = (m_reg == '0) && (k_reg == '0) && (c_reg == '0);
  assign cur_sig   = sym_start ? din_sig_flag : sig_reg;
  assign cur_map   = sym_start ? din_map_type : map_reg;
  assign nb_cur    = nbpsc_of(cur_sig, cur_map);
  assign s_cur     = s_of(nb_cur);
  assign l_cur     = KW'(COL_MULT) * KW'(nb_cur);

  assign din_rdy   = !full_v[wr_ptr_reg];
  assign in_fire   = din_vld && din_rdy;
  assign grp_done  = (m_reg == s_cur - SW'(1));
  assign col_done  = (k_reg == l_cur - KW'(1));
  assign sym_done  = col_done && (c_reg == CW'(NUM_COLS - 1));

  always_comb begin
    rd_s    = s_v[rd_ptr_reg];
    sel_sum = {1'b0, j_reg} + {1'b0, r_v[rd_ptr_reg]};
    if (sel_sum >= {1'b0, rd_s})
      sel_sum = sel_sum - {1'b0, rd_s};
    sel = sel_sum[SW-1:0];
  end

  assign dout_vld      = full_v[rd_ptr_reg];
  assign out_fire      = dout_vld && dout_rdy;
  assign out_grp_done  = (j_reg == rd_s - SW'(1));
  assign dout          = dout_vld && bits_v[rd_ptr_reg][sel];
  assign dout_map_type = map_v[rd_ptr_reg];
  assign dout_sym_last = dout_vld && last_v[rd_ptr_reg] && out_grp_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      m_reg      <= '0;
      k_reg      <= '0;
      c_reg      <= '0;
      r_reg      <= '0;
      sig_reg    <= 1'b0;
      map_reg    <= RESET_MAP_TYPE;
      wr_ptr_reg <= 1'b0;
    end else if (in_fire) begin
      if (sym_start) begin
        sig_reg <= din_sig_flag;
        map_reg <= din_map_type;
      end
      m_reg <= grp_done ? '0 : m_reg + SW'(1);
      k_reg <= col_done ? '0 : k_reg + KW'(1);
      // r tracks c mod s so no divider is needed
      if (col_done) begin
        if (sym_done) begin
          c_reg <= '0;
          r_reg <= '0;
        end else begin
          c_reg <= c_reg + CW'(1);
          r_reg <= (r_reg == s_cur - SW'(1)) ? '0 : r_reg + SW'(1);
        end
      end
      if (grp_done)
        wr_ptr_reg <= ~wr_ptr_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_reg <= 1'b0;
      j_reg      <= '0;
    end else if (out_fire) begin
      if (out_grp_done) begin
        j_reg      <= '0;
        rd_ptr_reg <= ~rd_ptr_reg;
      end else begin
        j_reg <= j_reg + SW'(1);
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_buf
      logic             full_reg;
      logic             last_reg;
      logic [MAX_S-1:0] bits_reg;
      logic [SW-1:0]    s_reg;
      logic [SW-1:0]    r_tag_reg;
      logic [1:0]       map_tag_reg;
      logic             fill;
      logic             free;

      assign fill = in_fire && (wr_ptr_reg == 1'(gi));
      assign free = out_fire && out_grp_done && (rd_ptr_reg == 1'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          full_reg    <= 1'b0;
          last_reg    <= 1'b0;
          bits_reg    <= '0;
          s_reg       <= SW'(1);
          r_tag_reg   <= '0;
          map_tag_reg <= RESET_MAP_TYPE;
        end else begin
          if (fill) begin
            bits_reg[m_reg] <= din;
            if (grp_done) begin
              full_reg    <= 1'b1;
              last_reg    <= sym_done;
              s_reg       <= s_cur;
              r_tag_reg   <= r_reg;
              map_tag_reg <= cur_map;
            end
          end
          if (free)
            full_reg <= 1'b0;
        end
      end

      assign full_v[gi] = full_reg;
      assign last_v[gi] = last_reg;
      assign bits_v[gi] = bits_reg;
      assign s_v[gi]    = s_reg;
      assign r_v[gi]    = r_tag_reg;
      assign map_v[gi]  = map_tag_reg;
    end
  endgenerate

endmodule

// File: tb/tb_interleaver_2_param.sv
// Scoreboard bench for interleaver_2_param: golden permutation from the
// 802.11a index formula, compared bit by bit as the DUT emits.
`timescale 1ns/1ps
module tb_interleaver_2_param;
  localparam int NC = 16;
  localparam int CM = 3;

  logic       clk;
  logic       rst;
  logic       din;
  logic       din_vld;
  logic       din_rdy;
  logic       din_sig_flag;
  logic [1:0] din_map_type;
  logic       dout;
  logic       dout_vld;
  logic       dout_rdy;
  logic [1:0] dout_map_type;
  logic       dout_sym_last;

  interleaver_2_param #(
    .NUM_COLS(NC), .COL_MULT(CM), .MAX_S(3), .RESET_MAP_TYPE(2'b11)
  ) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy),
    .din_sig_flag(din_sig_flag), .din_map_type(din_map_type),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy),
    .dout_map_type(dout_map_type), .dout_sym_last(dout_sym_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    logic       b;
    logic [1:0] mt;
    logic       last;
  } exp_t;

  exp_t exp_q[$];
  bit   sym_bits [288];
  bit   bp_mode = 1'b0;
  bit   saw_full_stall = 1'b0;
  int   last_out_cyc = 0;

  // Golden model straight from j = s*floor(i/s) + (i + Ncbps - floor(16i/Ncbps)) mod s
  function automatic void push_expected(input int nb, input int s, input logic [1:0] mt, input int count);
    int   ncbps;
    int   j;
    bit   ob [288];
    exp_t e;
    ncbps = NC * CM * nb;
    for (int i = 0; i < ncbps; i++) begin
      j = s * (i / s) + ((i + ncbps - (NC * i) / ncbps) % s);
      ob[j] = sym_bits[i];
    end
    for (int q = 0; q < count; q++) begin
      e.b = ob[q];
      e.mt = mt;
      e.last = (q == ncbps - 1);
      exp_q.push_back(e);
    end
  endfunction

  // Monitor: compare each accepted output bit and hold-stability under stall
  initial begin
    logic       prev_stall;
    logic [3:0] prev_out;
    exp_t       e;
    prev_stall = 1'b0;
    prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall)
          check("hold", 32'({dout_vld, dout, dout_map_type, dout_sym_last}), 32'({1'b1, prev_out}));
        if (dout_vld && dout_rdy) begin
          if (exp_q.size() == 0) begin
            check("unexpected_out", 32'(1), 32'(0));
          end else begin
            e = exp_q.pop_front();
            $display("out cyc=%0d dout=%0b map=%0b last=%0b exp=%0b/%0b/%0b",
                     cyc + 1, dout, dout_map_type, dout_sym_last, e.b, e.mt, e.last);
            check("dout", 32'(dout), 32'(e.b));
            check("dout_map_type", 32'(dout_map_type), 32'(e.mt));
            check("dout_sym_last", 32'(dout_sym_last), 32'(e.last));
          end
          if (dout_sym_last) last_out_cyc = cyc + 1;
        end
        if (bp_mode && din_vld && !din_rdy) saw_full_stall = 1'b1;
        prev_stall = dout_vld && !dout_rdy;
        prev_out = {dout, dout_map_type, dout_sym_last};
      end
    end
  end

  // Downstream ready: held high, or pseudo-random during the backpressure test
  initial begin
    dout_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      dout_rdy = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic drive_bit(input logic b, input logic sig, input logic [1:0] mt, output int acc_cyc);
    logic acc;
    din = b;
    din_sig_flag = sig;
    din_map_type = mt;
    din_vld = 1'b1;
    acc_cyc = -1;
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      acc = din_rdy;
      @(posedge clk);
      #1;
      if (acc) begin
        acc_cyc = cyc;
        din_vld = 1'b0;
        return;
      end
    end
    check("din_accept_timeout", 32'(0), 32'(1));
    din_vld = 1'b0;
  endtask

  task automatic send_symbol(input logic sig, input logic [1:0] mt, input logic [1:0] alt_mt,
                             input int chg_at, input int gap_pct, input int nbits,
                             input bit idx_pattern, input int push_count, output int first_cyc);
    int nb;
    int s;
    int ac;
    if (sig) nb = 1;
    else case (mt)
      2'b00: nb = 1;
      2'b01: nb = 2;
      2'b10: nb = 4;
      default: nb = 6;
    endcase
    s = (nb == 6) ? 3 : (nb == 4) ? 2 : 1;
    for (int i = 0; i < NC * CM * nb; i++)
      sym_bits[i] = idx_pattern ? i[0] : 1'($urandom_range(0, 1));
    push_expected(nb, s, mt, push_count);
    first_cyc = 0;
    for (int i = 0; i < nbits; i++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        @(posedge clk);
        #1;
      end
      drive_bit(sym_bits[i], sig, (i >= chg_at) ? alt_mt : mt, ac);
      if (i == 0) first_cyc = ac;
    end
  endtask

  task automatic wait_drain();
    int t;
    for (t = 0; t < 20000; t++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    if (exp_q.size() != 0) begin
      check("drain_timeout", 32'(exp_q.size()), 32'(0));
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int fc;
    rst = 1'b1;
    din = 1'b0;
    din_vld = 1'b0;
    din_sig_flag = 1'b0;
    din_map_type = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_dout", 32'(dout), 32'(0));
    check("rst_dout_vld", 32'(dout_vld), 32'(0));
    check("rst_sym_last", 32'(dout_sym_last), 32'(0));
    check("rst_map_type", 32'(dout_map_type), 32'(2'b11));
    check("rst_din_rdy", 32'(din_rdy), 32'(1));
    @(posedge clk);
    #1;

    // SIGNAL symbol: BPSK passthrough, 1-cycle latency
    send_symbol(1'b1, 2'b11, 2'b11, 9999, 0, 48, 1'b1, 48, fc);
    wait_drain();
    check("bpsk_last_out_latency", 32'(last_out_cyc - fc), 32'(48));

    // 16-QAM: odd columns swap pairs, 1 bit/cycle after 2-cycle fill
    send_symbol(1'b0, 2'b10, 2'b10, 9999, 0, 192, 1'b0, 192, fc);
    wait_drain();
    check("qam16_last_out_latency", 32'(last_out_cyc - fc), 32'(193));

    // 64-QAM: three-way rotation by column
    send_symbol(1'b0, 2'b11, 2'b11, 9999, 0, 288, 1'b0, 288, fc);
    wait_drain();
    check("qam64_last_out_latency", 32'(last_out_cyc - fc), 32'(290));

    // Backpressure with random ready and input gaps
    bp_mode = 1'b1;
    saw_full_stall = 1'b0;
    send_symbol(1'b0, 2'b10, 2'b10, 9999, 20, 192, 1'b0, 192, fc);
    wait_drain();
    bp_mode = 1'b0;
    check("din_rdy_low_when_full", 32'(saw_full_stall), 32'(1));
    @(posedge clk);
    #1;

    // Mode switch QPSK -> 64-QAM back to back, with mid-symbol map changes
    send_symbol(1'b0, 2'b01, 2'b10, 40, 0, 96, 1'b0, 96, fc);
    send_symbol(1'b0, 2'b11, 2'b00, 100, 0, 288, 1'b0, 288, fc);
    wait_drain();

    // Reset after 7 bits of 64-QAM: two full groups drain, partial one is dropped
    send_symbol(1'b0, 2'b11, 2'b11, 9999, 0, 7, 1'b0, 6, fc);
    wait_drain();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_dout_vld", 32'(dout_vld), 32'(0));
    check("midrst_map_type", 32'(dout_map_type), 32'(2'b11));
    check("midrst_din_rdy", 32'(din_rdy), 32'(1));
    check("midrst_sym_last", 32'(dout_sym_last), 32'(0));
    @(posedge clk);
    #1;
    send_symbol(1'b0, 2'b11, 2'b11, 9999, 0, 288, 1'b0, 288, fc);
    wait_drain();
    check("final_queue_empty", 32'(exp_q.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/interleaver_2_param.md
Name: interleaver_2_param

Overview:
- Generalised second-permutation stage of the OFDM transmit interleaver.
- Implements the 802.11a rule j = s*floor(i/s) + (i + Ncbps - floor(16*i/Ncbps)) mod s, with s = max(Nbpsc/2,1), for BPSK, QPSK, 16-QAM and 64-QAM.
- Sits between the first-permutation interleaver and the constellation mapper.
- Bit-serial valid/ready in and out, with ping-pong group buffering for sustained 1 bit/cycle; the modulation type is latched per symbol.

Parameters:
- NUM_COLS, 16: interleaver columns per symbol; the column index c runs 0..NUM_COLS-1.
- COL_MULT, 3: bits per column = COL_MULT*Nbpsc.
- MAX_S, 3: widest bit group; sets the group buffer width.
- RESET_MAP_TYPE, 2'b11: reset value of dout_map_type.

Ports:
- clk, in, 1: single clock.
- rst, in, 1: synchronous reset, active-high.
- din, in, 1: serial coded bit.
- din_vld, in, 1: din valid.
- din_rdy, out, 1: block can accept din.
- din_sig_flag, in, 1: SIGNAL symbol; forces BPSK handling.
- din_map_type, in, 2: 00 BPSK (Nbpsc 1), 01 QPSK (2), 10 16-QAM (4), 11 64-QAM (6).
- dout, out, 1: permuted bit.
- dout_vld, out, 1: dout valid.
- dout_rdy, in, 1: downstream ready.
- dout_map_type, out, 2: map type of the symbol currently on dout.
- dout_sym_last, out, 1: dout is the final bit (Ncbps-1) of its symbol.

Behaviour:
- Reset: synchronous, active-high, one clock, single reset domain.
  - Reset clears all counters and both buffers.
  - Outputs after reset: dout=0, dout_vld=0, dout_sym_last=0, dout_map_type=RESET_MAP_TYPE, din_rdy=1 from the first cycle after release.
  - Reset mid-symbol discards every partial group and the symbol context; no outputs are produced for the discarded data.
- Symbol context:
  - Latched on the first accepted bit of a symbol (input bit counter = 0): map type and sig flag.
  - sig_flag=1 forces Nbpsc=1 regardless of map type; the latched dout_map_type keeps the input value.
  - Changes on din_map_type or din_sig_flag mid-symbol are ignored until the next symbol.
- Derived per symbol:
  - s = 1, 1, 2, 3 for Nbpsc 1, 2, 4, 6.
  - Column length L = COL_MULT*Nbpsc.
  - Ncbps = NUM_COLS*L (48/96/192/288).
- Input counters, advancing on din_vld & din_rdy:
  - m: group position 0..s-1.
  - k: position within column 0..L-1.
  - c: column 0..NUM_COLS-1.
  - All counters wrap to 0 at the end of the symbol. L is divisible by s, so groups never straddle columns.
- Rotation: r = c mod s (no divider; a mod-s counter steps with c). Output bit j of a group = input bit ((j+r) mod s) of the same group.
- Buffering:
  - Two group buffers, each holding MAX_S bits plus tag {s, r, map_type, last}.
  - The write pointer fills one buffer; the buffer is marked full on its s-th bit. The read pointer drains the other buffer.
  - din_rdy = buffer at the write pointer not full.
  - dout_vld = buffer at the read pointer full. The buffer frees on acceptance of its s-th output bit.
  - Simultaneous free and fill of the same buffer is not possible. Fill of one buffer and free of the other in the same cycle are both honoured.
- Latency and throughput:
  - First dout bit of a group is valid in the cycle after the group's last input bit is accepted.
  - Sustains 1 bit/cycle with dout_rdy held high.
- Backpressure: while dout_vld=1 and dout_rdy=0, dout, dout_map_type and dout_sym_last hold stable. When both buffers are full, din_rdy=0.
- Passthrough: for s=1 the block is a pure 1-cycle registered pipeline, bit order unchanged.
- Symbol boundaries: the next symbol may begin filling while the previous symbol's last group drains. dout_map_type changes with the first bit of the new symbol.

Test Plan:
- BPSK, sig_flag=1, map_type=11, 48 bits of pattern 0..47 (bit = index LSB), dout_rdy=1 → identical 48-bit sequence, 1-cycle latency, dout_map_type=11, dout_sym_last on bit 47 only.
- 16-QAM, 192 sequential indices, dout_rdy=1 →
  - Even columns (c=0,2,..) unchanged; odd columns output pairs swapped: index 12 emitted after 13.
  - Throughput 1 bit/cycle after a 2-cycle fill.
- 64-QAM, 288 bits → column 0 group {a,b,c} out a,b,c; column 1 out b,c,a; column 2 out c,a,b; column 3 repeats column 0.
- Backpressure: 16-QAM stream with dout_rdy toggling 1/0 pseudo-randomly and din_vld gaps → output equals the golden permutation. dout is stable while stalled, and din_rdy=0 when both buffers are full.
- Mode switch: QPSK symbol (96 bits) back-to-back with a 64-QAM symbol →
  - QPSK output unpermuted.
  - 64-QAM permutation starts at its bit 0.
  - dout_map_type changes 01→11 exactly on the first 64-QAM output bit.
  - A map_type change driven mid-symbol has no effect.
- Reset: assert rst for 1 cycle after 7 bits of a 64-QAM symbol → next cycle dout_vld=0, dout_map_type=11, din_rdy=1. The next 288-bit symbol permutes correctly from c=0.
